// File: rtl/chunked_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chunked_adder_pkg
// Purpose  : Shared constants and FSM state encoding for the chunked adder.
// Revision : 1.0 - initial release
// ============================================================================
package chunked_adder_pkg;

    localparam int c_WIDTH = 10;
    localparam int c_CHUNK = 2;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_RUN  = 2'd1;
    localparam state_t c_DONE = 2'd2;

endpackage : chunked_adder_pkg
`default_nettype wire

// File: rtl/chunked_adder_chunk_add.sv
`default_nettype none
// ============================================================================
// Module   : chunk_add
// Purpose  : CHUNK-bit combinational ripple adder; also exposes the carry into
//            its MSB so the caller can derive signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module chunk_add #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_c[CHUNK];
    assign cmsb = w_c[CHUNK-1];

endmodule : chunk_add
`default_nettype wire

// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunked_adder
// Purpose  : Multi-cycle add/subtract that processes CHUNK bits per cycle
//            through one shared ripple adder.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int CHUNK = c_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NCHUNK = WIDTH / CHUNK;
    localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCHUNK - 1);

    state_t             r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [CHUNK-1:0]   w_aChunks [c_NCHUNK];
    logic [CHUNK-1:0]   w_bChunks [c_NCHUNK];
    logic [CHUNK-1:0]   w_aChunk;
    logic [CHUNK-1:0]   w_bChunk;
    logic [CHUNK-1:0]   w_s;
    logic               w_cout;
    logic               w_cmsb;
    logic [WIDTH-1:0]   w_workNext;
    logic               w_last;

    // Split operands into chunks and splice the fresh adder slice into the
    // working value at the current index.
    for (genvar g = 0; g < c_NCHUNK; g++) begin : g_slice
        assign w_aChunks[g] = r_a[g*CHUNK +: CHUNK];
        assign w_bChunks[g] = r_b[g*CHUNK +: CHUNK];
        assign w_workNext[g*CHUNK +: CHUNK] =
            (r_idx == c_IDX_W'(g)) ? w_s : r_work[g*CHUNK +: CHUNK];
    end

    assign w_aChunk = w_aChunks[r_idx];
    assign w_bChunk = w_bChunks[r_idx];
    assign w_last   = (r_idx == c_LAST_IDX);

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunkAdd (
        .a    (w_aChunk),
        .b    (w_bChunk),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_work  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B and seed carry.
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_work  <= w_workNext;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_sum   <= w_workNext;
                        r_cout  <= w_cout;
                        r_ovf   <= w_cout ^ w_cmsb;
                        r_state <= c_DONE;
                    end else begin
                        r_idx   <= r_idx + c_IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == c_RUN);
    assign done = (r_state == c_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : chunked_adder
`default_nettype wire

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001: The block SHALL have parameter WIDTH, default 10, operand and result width in bits.
REQ-002: The block SHALL have parameter CHUNK, default 2, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: start  input  1  request a new operation; sampled only when not busy.
REQ-006: sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007: a  input  WIDTH  operand A; sampled with start.
REQ-008: b  input  WIDTH  operand B; sampled with start.
REQ-009: busy  output  1  high while an operation is in progress.
REQ-010: done  output  1  one-cycle pulse when the result is valid.
REQ-011: sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012: cout  output  1  carry out of the MSB; for sub, 1 means A >= B unsigned.
REQ-013: ovf  output  1  two's-complement signed overflow of the completed operation.

Function
REQ-014: The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015: In IDLE or DONE, start=1 SHALL latch a, b XOR {WIDTH{sub}} and carry = sub, clear the chunk index, and move to RUN.
REQ-016: In RUN, each cycle SHALL add chunk[idx] of the latched operands plus the carry register, write that CHUNK-bit slice into the working register, update carry, and increment idx.
REQ-017: After the chunk at idx = NCHUNK-1 the FSM SHALL enter DONE, copy the working register to sum, and update cout and ovf.
REQ-018: ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-019: Latency SHALL be fixed: start is sampled at edge k, and done is high in the cycle after edge k+NCHUNK (NCHUNK+1 cycles); busy is high in exactly the NCHUNK RUN cycles.
REQ-020: done SHALL be high only in DONE, for exactly one cycle; DONE with no start SHALL return to IDLE.
REQ-021: start while busy SHALL be ignored; latched operands and sub SHALL NOT change mid-operation.
REQ-022: start in the DONE cycle SHALL be accepted (back-to-back), giving RUN on the next cycle with no IDLE gap.
REQ-023: sum, cout and ovf SHALL hold the previous result through IDLE and RUN, and change only on entry to DONE.
REQ-024: Arithmetic SHALL wrap modulo 2^WIDTH; the carry beyond cout SHALL be discarded.

Reset
REQ-025: rst=1 at a clock edge SHALL force IDLE and clear busy, done, sum, cout, ovf, idx, carry and the working registers to 0, overriding start.
REQ-026: rst asserted during RUN or DONE SHALL abort the operation without a done pulse.
REQ-027: A start in the first cycle after rst is released SHALL be accepted normally.

Structure
REQ-028: A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the default WIDTH and CHUNK constants.
REQ-029: One combinational sub-module chunk_add SHALL implement a CHUNK-bit ripple adder with inputs a, b, cin and outputs s, cout, cmsb (carry into its MSB).
REQ-030: chunk_add SHALL be instantiated once and multiplexed over chunk index; no WIDTH-wide adder is permitted.

Verification (WIDTH=10, CHUNK=2, NCHUNK=5)
REQ-031: a=1023, b=1, sub=0 -> done 6 cycles after start; sum=0, cout=1, ovf=0; busy high exactly 5 cycles.
REQ-032: a=511, b=1, sub=0 -> sum=512, cout=0, ovf=1.
REQ-033: a=5, b=7, sub=1 -> sum=1022, cout=0, ovf=0; then a=7, b=5, sub=1 -> sum=2, cout=1, ovf=0.
REQ-034: start a=3, b=4; at the 2nd RUN cycle pulse start with a=100, b=100 -> single done, sum=7, no second done.
REQ-035: start a=10, b=20; assert rst in the 3rd RUN cycle -> next cycle busy=0, done=0, sum=0; a later start a=1, b=2 gives sum=3 after 6 cycles.
REQ-036: start held high continuously with a=1, b=1 -> done pulses every 6 cycles (RUN x5, DONE x1), sum=2 each time.
